axil_apb_bridge_ms: RTL

AXIL_APB_BRIDGE_MS -- requirements
Module: axil_apb_bridge_ms

---
 rtl/axil_apb_bridge_ms.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/axil_apb_bridge_ms.sv
// AXI4-Lite to APB bridge: one transfer in flight, completer picked by addr[SEL_LSB +: clog2(NUM_SLV)].
// Define APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYC cycles.
module axil_apb_bridge_ms #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_SLV     = 4,
  parameter int unsigned SEL_LSB     = 12,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [ADDR_WIDTH-1:0]         AWADDR,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [DATA_WIDTH-1:0]         WDATA,
  input  logic [DATA_WIDTH/8-1:0]       WSTRB,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [ADDR_WIDTH-1:0]         ARADDR,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  output logic [DATA_WIDTH-1:0]         RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RVALID,
  input  logic                          RREADY,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [NUM_SLV-1:0]            PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  output logic [DATA_WIDTH/8-1:0]       PSTRB,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]            PREADY,
  input  logic [NUM_SLV-1:0]            PSLVERR
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned SelW  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [SelW:0] NumSlvW = (SelW + 1)'(NUM_SLV);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]        strb_q, strb_d;
  logic                    write_q, write_d;
  logic [SelW-1:0]         idx_q, idx_d;
  logic [1:0]              resp_q, resp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    pref_wr_q, pref_wr_d;
  logic                    grant_wr, grant_rd;
  logic                    sel_ready, sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  // Alternating priority only matters when both directions are eligible.
  assign grant_wr = (state_q == StIdle) && AWVALID && WVALID && (pref_wr_q || !ARVALID);
  assign grant_rd = (state_q == StIdle) && ARVALID && !grant_wr;

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (idx_q == SelW'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    write_d   = write_q;
    idx_d     = idx_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    pref_wr_d = pref_wr_q;
`ifdef APB_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_wr || grant_rd) begin
          addr_d    = grant_wr ? AWADDR : ARADDR;
          wdata_d   = grant_wr ? WDATA : '0;
          strb_d    = grant_wr ? WSTRB : '0;
          write_d   = grant_wr;
          idx_d     = addr_d[SEL_LSB +: SelW];
          pref_wr_d = grant_rd;
          if ({1'b0, idx_d} < NumSlvW) begin
            state_d = StSetup;
          end else begin
            state_d = StResp;
            resp_d  = 2'b11;
            rdata_d = grant_rd ? '0 : rdata_q;
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
`ifdef APB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      StAccess: begin
        if (sel_ready) begin
          state_d = StResp;
          resp_d  = sel_err ? 2'b10 : 2'b00;
          rdata_d = write_q ? rdata_q : sel_rdata;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
          state_d = StResp;
          resp_d  = 2'b10;
          rdata_d = write_q ? rdata_q : '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      StResp: begin
        if (write_q ? BREADY : RREADY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      resp_q    <= 2'b00;
      rdata_q   <= '0;
      pref_wr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      write_q   <= write_d;
      idx_q     <= idx_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      pref_wr_q <= pref_wr_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`endif

  // Only a decoded index ever reaches SETUP, so PSEL stays one-hot or zero.
  always_comb begin
    PSEL = '0;
    if (state_q == StSetup || state_q == StAccess) begin
      for (int unsigned i = 0; i < NUM_SLV; i++) PSEL[i] = (idx_q == SelW'(i));
    end
  end

  // Handshake outputs are forced low while reset is held, even with valids pending.
  assign AWREADY = grant_wr && ARESETn;
  assign WREADY  = grant_wr && ARESETn;
  assign ARREADY = grant_rd && ARESETn;
  assign PENABLE = (state_q == StAccess);
  assign PADDR   = addr_q;
  assign PWRITE  = write_q;
  assign PWDATA  = wdata_q;
  assign PSTRB   = strb_q;
  assign BVALID  = (state_q == StResp) && write_q;
  assign RVALID  = (state_q == StResp) && !write_q;
  assign BRESP   = resp_q;
  assign RRESP   = resp_q;
  assign RDATA   = rdata_q;

endmodule
